// File: rtl/controle_exibicao_pkg.sv
// Shared definitions for the scrolling-panel mode sequencer: mode encodings
// and the helpers that step through them.
package controle_exibicao_pkg;

    typedef enum logic [1:0] {
        MODO_EXIBE   = 2'b00,
        MODO_DIR_ESQ = 2'b01,
        MODO_ESQ_DIR = 2'b10
    } modo_t;

    // 00 -> 01 -> 10 -> 00; the unused code 11 also falls back to static.
    function automatic modo_t prox_modo(input modo_t m);
        modo_t r;
        case (m)
            MODO_EXIBE:   r = MODO_DIR_ESQ;
            MODO_DIR_ESQ: r = MODO_ESQ_DIR;
            default:      r = MODO_EXIBE;
        endcase
        return r;
    endfunction

    function automatic modo_t inverte_dir(input modo_t m);
        return (m == MODO_DIR_ESQ) ? MODO_ESQ_DIR : MODO_DIR_ESQ;
    endfunction

endpackage

// File: rtl/controle_exibicao_divisor_tick.sv
// Shift-rate prescaler: counts 0..DIV_TICK-1 while enabled and flags the
// terminal count combinationally from the registered count.
module controle_exibicao_divisor_tick #(
    parameter int DIV_TICK = 50000
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int LARG_DIV = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [LARG_DIV-1:0] ULTIMO = LARG_DIV'(DIV_TICK - 1);

    logic [LARG_DIV-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == ULTIMO);

    // Clear has priority so a mode change always restarts the step period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (tc)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + LARG_DIV'(1);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/controle_exibicao.sv
// Mode sequencer for the scrolling message panel: drives the 2-bit select of
// the per-bit mode multiplexers, paced by the prescaler and a column counter.
module controle_exibicao
    import controle_exibicao_pkg::*;
#(
    parameter int DIV_TICK    = 50000,
    parameter int NUM_COLUNAS = 35,
    parameter int LARG_COL    = $clog2(NUM_COLUNAS)
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                btn_modo,
    input  logic                btn_pausa,
    input  logic                auto_ciclo,
    output logic                ch0,
    output logic                ch1,
    output logic                habilita_shift,
    output logic [1:0]          modo_atual,
    output logic [LARG_COL-1:0] coluna,
    output logic                passagem_fim,
    output logic                pausado
);

    localparam logic [LARG_COL-1:0] COL_ULTIMA = LARG_COL'(NUM_COLUNAS - 1);

    modo_t               modo_q, modo_d;
    logic                pausado_q, pausado_d;
    logic [LARG_COL-1:0] coluna_q, coluna_d;
    logic                hab_q, hab_d;
    logic                fim_q, fim_d;
    logic [1:0]          ch_q, ch_d;
    logic                div_en, div_clr, tick;

    controle_exibicao_divisor_tick #(
        .DIV_TICK(DIV_TICK)
    ) u_divisor (
        .clock(clock),
        .rst_n(rst_n),
        .en   (div_en),
        .clr  (div_clr),
        .tc   (tick)
    );

    assign div_en = (modo_q != MODO_EXIBE) && !pausado_q;

    always_comb begin
        modo_d    = modo_q;
        pausado_d = pausado_q;
        coluna_d  = coluna_q;
        hab_d     = 1'b0;
        fim_d     = 1'b0;
        ch_d      = 2'b00;
        div_clr   = 1'b0;

        if (btn_modo) begin
            // A button press overrides everything, including a pending step.
            modo_d    = prox_modo(modo_q);
            pausado_d = 1'b0;
            coluna_d  = '0;
            div_clr   = 1'b1;
        end else begin
            if (tick) begin
                hab_d    = 1'b1;
                ch_d     = modo_q;
                fim_d    = (coluna_q == COL_ULTIMA);
                coluna_d = (coluna_q == COL_ULTIMA) ? '0 : coluna_q + LARG_COL'(1);
            end
            if (auto_ciclo && fim_q && (modo_q != MODO_EXIBE)) begin
                modo_d   = inverte_dir(modo_q);
                coluna_d = '0;
                div_clr  = 1'b1;
            end
            if (btn_pausa && (modo_q != MODO_EXIBE))
                pausado_d = !pausado_q;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            modo_q    <= MODO_EXIBE;
            pausado_q <= 1'b0;
            coluna_q  <= '0;
            hab_q     <= 1'b0;
            fim_q     <= 1'b0;
            ch_q      <= 2'b00;
        end else begin
            modo_q    <= modo_d;
            pausado_q <= pausado_d;
            coluna_q  <= coluna_d;
            hab_q     <= hab_d;
            fim_q     <= fim_d;
            ch_q      <= ch_d;
        end
    end

    assign ch0            = ch_q[0];
    assign ch1            = ch_q[1];
    assign habilita_shift = hab_q;
    assign modo_atual     = modo_q;
    assign coluna         = coluna_q;
    assign passagem_fim   = fim_q;
    assign pausado        = pausado_q;

endmodule

// File: tb/tb_controle_exibicao.sv
// Directed bench for controle_exibicao with DIV_TICK=4, NUM_COLUNAS=3.
module tb_controle_exibicao;

    localparam int DIV = 4;
    localparam int NC  = 3;

    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_modo = 1'b0;
    logic       btn_pausa = 1'b0;
    logic       auto_ciclo = 1'b0;
    logic       ch0, ch1, habilita_shift, passagem_fim, pausado;
    logic [1:0] modo_atual;
    logic [1:0] coluna;
    logic [8:0] o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    controle_exibicao #(
        .DIV_TICK   (DIV),
        .NUM_COLUNAS(NC)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .btn_modo      (btn_modo),
        .btn_pausa     (btn_pausa),
        .auto_ciclo    (auto_ciclo),
        .ch0           (ch0),
        .ch1           (ch1),
        .habilita_shift(habilita_shift),
        .modo_atual    (modo_atual),
        .coluna        (coluna),
        .passagem_fim  (passagem_fim),
        .pausado       (pausado)
    );

    // Observed vector layout: {ch1,ch0, habilita_shift, passagem_fim, pausado, modo_atual, coluna}
    assign o = {ch1, ch0, habilita_shift, passagem_fim, pausado, modo_atual, coluna};

    function automatic logic [8:0] ev(input logic [1:0] ch, input logic h, input logic f,
                                      input logic p, input logic [1:0] m, input logic [1:0] c);
        return {ch, h, f, p, m, c};
    endfunction

    // Expected outputs for cycle c (1..16) after a fresh entry into scroll mode m.
    function automatic logic [8:0] scroll(input int c, input logic [1:0] m);
        logic       h;
        logic [1:0] col;
        h = (c == 5) || (c == 9) || (c == 13);
        if (c < 5)       col = 2'd0;
        else if (c < 9)  col = 2'd1;
        else if (c < 13) col = 2'd2;
        else             col = 2'd0;
        return ev(h ? m : 2'b00, h, c == 13, 1'b0, m, col);
    endfunction

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset asserted between edges must clear outputs without a clock.
        #2 rst_n = 1'b0;
        #1 chk("rst_async", o, 9'd0);
        ciclo();
        ciclo();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("idle", o, 9'd0);
            ciclo();
        end

        // Enter right-to-left scrolling; pulses expected at cycles 5, 9, 13.
        btn_modo = 1'b1;
        ciclo();
        btn_modo = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("scroll_c%0d", c), o, scroll(c, 2'b01));
            ciclo();
        end
        chk("step_c17", o, ev(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'd1));

        // Pause two cycles after a step, hold 10 cycles, then resume.
        ciclo();
        ciclo();
        btn_pausa = 1'b1;
        chk("pre_pause", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1));
        ciclo();
        btn_pausa = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("paused_%0d", k), o, ev(2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 2'd1));
            if (k == 9) btn_pausa = 1'b1;
            ciclo();
        end
        btn_pausa = 1'b0;
        chk("resume", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'd1));
        ciclo();
        chk("resume_step", o, ev(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'd2));

        // Held btn_modo advances every cycle: 01 -> 10 -> 00 -> 01.
        btn_modo = 1'b1;
        ciclo();
        chk("hold_m10", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'd0));
        ciclo();
        chk("hold_m00", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0));
        auto_ciclo = 1'b1;
        ciclo();
        btn_modo = 1'b0;

        // Auto direction change after the end of pass.
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("auto_c%0d", c), o, scroll(c, 2'b01));
            ciclo();
        end
        for (int c = 14; c <= 17; c++) begin
            chk($sformatf("auto_c%0d", c), o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'd0));
            ciclo();
        end
        chk("auto_c18", o, ev(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 2'd1));
        auto_ciclo = 1'b0;

        // btn_modo on the terminal-count cycle discards the step.
        ciclo();
        ciclo();
        ciclo();
        btn_modo = 1'b1;
        ciclo();
        btn_modo = 1'b0;
        chk("modo_on_tc", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0));
        ciclo();
        chk("static_quiet", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0));
        btn_pausa = 1'b1;
        ciclo();
        btn_pausa = 1'b0;
        chk("pause_ign_00", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0));

        btn_modo = 1'b1;
        ciclo();
        btn_modo = 1'b0;
        chk("m01_again", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'd0));
        btn_pausa = 1'b1;
        ciclo();
        btn_pausa = 1'b0;
        chk("paused_01", o, ev(2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 2'd0));
        btn_modo  = 1'b1;
        btn_pausa = 1'b1;
        ciclo();
        btn_modo  = 1'b0;
        btn_pausa = 1'b0;
        chk("modo_pausa", o, ev(2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'd0));

        // Pause on the terminal-count cycle: step still emitted, then frozen.
        ciclo();
        ciclo();
        ciclo();
        btn_pausa = 1'b1;
        ciclo();
        btn_pausa = 1'b0;
        chk("pause_on_tc", o, ev(2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 2'd1));
        ciclo();
        chk("frozen_a", o, ev(2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 2'd1));
        ciclo();
        ciclo();
        ciclo();
        chk("frozen_b", o, ev(2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 2'd1));

        // Mid-operation asynchronous reset, then normal restart from mode 00.
        #3 rst_n = 1'b0;
        #1 chk("rst_mid", o, 9'd0);
        ciclo();
        chk("rst_hold", o, 9'd0);
        rst_n = 1'b1;
        ciclo();
        chk("post_rst", o, 9'd0);
        btn_modo = 1'b1;
        ciclo();
        btn_modo = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("restart_c%0d", c), o, scroll(c, 2'b01));
            ciclo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_exibicao.md
Name: controle_exibicao

Overview:
- Mode sequencer for the scrolling message panel. It produces the 2-bit select code (ch1, ch0) that feeds the panel's per-bit 3-way mode multiplexers, so it sits at the source end of the select lines.
- The select code picks one of three register inputs: hold/static, right-to-left shift, left-to-right shift.
- It converts button pulses into mode changes, paces shifts with a prescaler, counts columns per pass, and can alternate scroll direction automatically.

Parameters:
DIV_TICK, 50000, clock cycles per shift step; legal range >= 2
NUM_COLUNAS, 35, shift steps per full message pass; legal range >= 2
LARG_COL, $clog2(NUM_COLUNAS), width of the column counter (derived)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
btn_modo  in  1  single-cycle pulse, synchronous and debounced upstream: advance mode
btn_pausa  in  1  single-cycle pulse: toggle pause (scroll modes only)
auto_ciclo  in  1  level: alternate scroll direction at each end of pass
ch0  out  1  select bit 0 to the mode multiplexers
ch1  out  1  select bit 1 to the mode multiplexers
habilita_shift  out  1  one-cycle pulse, asserted when a shift is applied
modo_atual  out  2  current mode: 00 static, 01 right-to-left, 10 left-to-right
coluna  out  LARG_COL  shift steps completed in the current pass
passagem_fim  out  1  one-cycle pulse on the last step of a pass
pausado  out  1  pause flag

Behaviour:
- Reset (rst_n=0, asynchronous, also mid-operation):
  - all outputs 0;
  - modo=00, divider=0, coluna=0, pausado=0.
- Mode cycle: 00 -> 01 -> 10 -> 00. Code 11 is never produced.
- Select gating:
  - {ch1,ch0} = modo_atual only in cycles where habilita_shift=1; otherwise 00, so the register recirculates/holds.
  - In mode 00, {ch1,ch0} is always 00.
- Divider:
  - runs only when modo != 00 and pausado=0;
  - counts 0..DIV_TICK-1 and wraps to 0;
  - when terminal count is reached in cycle N, the registered outputs habilita_shift and ch are asserted in cycle N+1 for exactly one cycle.
- Column counter:
  - increments on each step;
  - the step that finds coluna=NUM_COLUNAS-1 wraps it to 0 and asserts passagem_fim in the same cycle as habilita_shift.
- btn_modo:
  - advances the mode at the next edge;
  - clears divider, coluna and pausado;
  - a step pending in the same cycle is discarded (no pulse);
  - holding btn_modo high advances the mode every cycle, so the input must be a pulse.
- btn_pausa:
  - toggles pausado in modes 01/10; ignored in mode 00;
  - while paused, divider and coluna freeze at their values;
  - on resume, counting continues from the frozen divider value.
- Simultaneous btn_modo and btn_pausa: btn_modo wins and pausado ends 0.
- Simultaneous btn_pausa and terminal count: the pending step is still emitted, then the block freezes.
- auto_ciclo=1:
  - at passagem_fim in mode 01 or 10, the mode toggles 01<->10 at the next edge, and divider/coluna restart at 0;
  - auto_ciclo has no effect in mode 00.
- Simultaneous btn_modo and an auto toggle: btn_modo applies, using the pre-toggle mode as its starting point.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package:
  - mode encodings MODO_EXIBE=2'b00, MODO_DIR_ESQ=2'b01, MODO_ESQ_DIR=2'b10;
  - 2-bit mode typedef (also used by the multiplexer instances and the top level).
- Sub-module divisor_tick:
  - prescaler with enable, synchronous clear and a one-cycle terminal-count output;
  - parameter DIV_TICK; same clock/reset.
- The FSM, column counter and output registers stay in controle_exibicao.

Test Plan (DIV_TICK=4, NUM_COLUNAS=3):
1. Release reset, idle 20 cycles -> ch=00, habilita_shift=0, modo_atual=00, coluna=0 throughout.
2. btn_modo at cycle 0 -> modo_atual=01 from cycle 1; habilita_shift with ch=01 at cycles 5, 9, 13 only; coluna goes 1, 2, 0; passagem_fim only at cycle 13.
3. Mode 01, btn_pausa two cycles after a step, held 10 cycles, then btn_pausa again -> no pulses while paused; next pulse comes 2 cycles after resume; pausado tracks the pause.
4. auto_ciclo=1, mode 01 -> after passagem_fim at cycle 13, modo_atual=10 at cycle 14 and the next pulse (ch=10) at cycle 18.
5. btn_modo in the same cycle as the divider terminal count -> no habilita_shift, modo advances, coluna=0; btn_modo with btn_pausa -> pausado=0.
6. rst_n low mid-scroll, between edges -> all outputs 0 immediately (no clock edge needed); normal operation resumes from mode 00 after release.
